// File: rtl/mmio_timer_if.sv
// Processor DATA/ADDR/READ/WRITE bus as seen by the timer peripheral.
// The shared DATA wire is resolved here from the responder and requester drive enables.
interface mmio_timer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 26
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic              hit;
    logic              irq;
    logic              oe;
    logic [DATA_W-1:0] rdata;
    logic              mdrive;
    logic [DATA_W-1:0] wdata;
    wire  [DATA_W-1:0] data;

    // Responder has priority; it only drives when the requester is not writing.
    assign data = oe ? rdata : (mdrive ? wdata : 'z);

    modport slave (
        input  addr, read, write, data,
        output hit, irq, oe, rdata
    );

    modport master (
        output addr, read, write, mdrive, wdata,
        input  hit, irq, data, oe
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, overflow flag and IRQ.
// Four-word register window: CTRL, COUNT, COMPARE, STATUS (write-1-to-clear).
module mmio_timer #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 26,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 26'h3FFFFFC
) (
    input  logic        clk,
    input  logic        rst,
    mmio_timer_if.slave bus
);
    typedef enum logic {IDLE, COUNTING} state_t;

    state_t            state, state_nxt;
    logic              auto_reload, irq_en;
    logic [7:0]        prescale, psc, psc_nxt;
    logic [DATA_W-1:0] count, compare, count_tick;
    logic              match, ovf;
    logic              hit, rd, wr;
    logic [1:0]        off;
    logic              wr_ctrl, wr_count, wr_compare, wr_status;
    logic              tick, reload, match_set, ovf_set;

    assign hit = (bus.addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
    assign off = bus.addr[1:0];
    // DATA stays released while reset is asserted, even for a decoded read.
    assign rd  = hit & bus.read & ~bus.write & ~rst;
    assign wr  = hit & bus.write & ~bus.read;

    assign wr_ctrl    = wr && (off == 2'd0);
    assign wr_count   = wr && (off == 2'd1);
    assign wr_compare = wr && (off == 2'd2);
    assign wr_status  = wr && (off == 2'd3);

    assign tick       = (state == COUNTING) && (psc == prescale);
    assign reload     = auto_reload && (count == compare);
    assign count_tick = reload ? '0 : count + DATA_W'(1);
    // A COUNT write on a tick edge suppresses both the increment and the flags.
    assign match_set  = tick && !wr_count && (count_tick == compare);
    assign ovf_set    = tick && !wr_count && !reload && (count == '1);

    always_comb begin
        state_nxt = state;
        if (wr_ctrl)
            state_nxt = bus.data[0] ? COUNTING : IDLE;
    end

    always_comb begin
        psc_nxt = psc;
        if (state == COUNTING)
            psc_nxt = tick ? 8'd0 : psc + 8'd1;
        if (wr_ctrl && (bus.data[15:8] != prescale))
            psc_nxt = 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 8'd0;
            psc         <= 8'd0;
            count       <= '0;
            compare     <= '0;
            match       <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state <= state_nxt;
            psc   <= psc_nxt;
            if (wr_ctrl) begin
                auto_reload <= bus.data[1];
                irq_en      <= bus.data[2];
                prescale    <= bus.data[15:8];
            end
            if (wr_count)
                count <= bus.data;
            else if (tick)
                count <= count_tick;
            if (wr_compare)
                compare <= bus.data;
            // Set events win over a simultaneous write-1-to-clear.
            match <= match_set | (match & ~(wr_status & bus.data[0]));
            ovf   <= ovf_set   | (ovf   & ~(wr_status & bus.data[1]));
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (off)
            2'd0: bus.rdata = {16'd0, prescale, 5'd0, irq_en, auto_reload,
                               (state == COUNTING)};
            2'd1: bus.rdata = count;
            2'd2: bus.rdata = compare;
            default: bus.rdata = {30'd0, ovf, match};
        endcase
    end

    assign bus.oe  = rd;
    assign bus.hit = hit;
    assign bus.irq = irq_en & (match | ovf);
endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: register table, then timer corner-case sequences.
module tb_mmio_timer;
    localparam logic [25:0] BASE = 26'h3FFFFFC;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [31:0] exp_q[$];

    mmio_timer_if #(.DATA_W(32), .ADDR_W(26)) bus ();

    mmio_timer #(.DATA_W(32), .ADDR_W(26), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] o, input logic [31:0] d);
        bus.addr   = BASE + 26'(o);
        bus.write  = 1'b1;
        bus.mdrive = 1'b1;
        bus.wdata  = d;
        @(posedge clk);
        #1;
        bus.write  = 1'b0;
        bus.mdrive = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] o, input logic [31:0] e);
        exp_q.push_back(e);
        bus.addr = BASE + 26'(o);
        bus.read = 1'b1;
        #1;
        chk({nm, "_oe"}, 32'(bus.oe), 32'd1);
        chk(nm, bus.data, exp_q.pop_front());
        bus.read = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.addr   = BASE;
        bus.read   = 1'b0;
        bus.write  = 1'b0;
        bus.mdrive = 1'b0;
        bus.wdata  = '0;

        tbl[0] = '{"ctrl_mask",   2'd0, 32'hFFFF_FF06, 32'h0000_FF06};
        tbl[1] = '{"compare_rw",  2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[2] = '{"count_rw",    2'd1, 32'h1234_5678, 32'h1234_5678};
        tbl[3] = '{"status_w1c0", 2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[4] = '{"ctrl_zero",   2'd0, 32'h0000_0000, 32'h0000_0000};

        idle(2);
        rst = 1'b0;
        #1;
        rd_chk("rst_ctrl",    2'd0, 32'd0);
        rd_chk("rst_count",   2'd1, 32'd0);
        rd_chk("rst_compare", 2'd2, 32'd0);
        rd_chk("rst_status",  2'd3, 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);

        for (int i = 0; i < 5; i++) begin
            wr(tbl[i].off, tbl[i].wd);
            rd_chk(tbl[i].name, tbl[i].off, tbl[i].exp);
        end

        // READ and WRITE together: no write, DATA released
        bus.addr   = BASE + 26'd1;
        bus.read   = 1'b1;
        bus.write  = 1'b1;
        bus.mdrive = 1'b1;
        bus.wdata  = 32'hAAAA_5555;
        #1;
        chk("rw_both_oe", 32'(bus.oe), 32'd0);
        @(posedge clk);
        #1;
        bus.read   = 1'b0;
        bus.write  = 1'b0;
        bus.mdrive = 1'b0;
        rd_chk("rw_both_nochange", 2'd1, 32'h1234_5678);

        // Just below the window
        bus.addr = BASE - 26'd1;
        bus.read = 1'b1;
        #1;
        chk("miss_hit", 32'(bus.hit), 32'd0);
        chk("miss_oe", 32'(bus.oe), 32'd0);
        bus.read = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.addr   = BASE - 26'(k);
            bus.write  = 1'b1;
            bus.mdrive = 1'b1;
            bus.wdata  = 32'h1111_1111;
            @(posedge clk);
            #1;
        end
        bus.write  = 1'b0;
        bus.mdrive = 1'b0;
        rd_chk("miss_count",   2'd1, 32'h1234_5678);
        rd_chk("miss_compare", 2'd2, 32'hDEAD_BEEF);
        bus.addr = BASE;
        #1;
        chk("base_hit", 32'(bus.hit), 32'd1);

        // Prescale 3: one tick every 4 cycles
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h0000_0301);
        idle(3);
        rd_chk("psc_before_tick", 2'd1, 32'd0);
        idle(1);
        rd_chk("psc_first_tick", 2'd1, 32'd1);
        idle(36);
        rd_chk("psc_40_cycles", 2'd1, 32'd10);
        wr(2'd0, 32'd0);
        idle(2);
        rd_chk("psc_stopped", 2'd1, 32'd10);

        // Auto-reload with compare 4 and IRQ enabled
        wr(2'd3, 32'd3);
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h0000_0007);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.addr = BASE + 26'd1;
            bus.read = 1'b1;
            #1;
            chk("ar_count_seq", bus.data, exp_q.pop_front());
            bus.read = 1'b0;
            if (i == 2) chk("ar_irq_before", 32'(bus.irq), 32'd0);
            if (i == 3) chk("ar_irq_match", 32'(bus.irq), 32'd1);
        end
        wr(2'd3, 32'd1);
        chk("ar_irq_cleared", 32'(bus.irq), 32'd0);
        rd_chk("ar_status_cleared", 2'd3, 32'd0);
        idle(1);
        wr(2'd3, 32'd1);
        rd_chk("coll_count4", 2'd1, 32'd4);
        rd_chk("coll_match_wins", 2'd3, 32'd1);
        wr(2'd3, 32'd3);
        rd_chk("reload_no_match", 2'd3, 32'd0);
        wr(2'd1, 32'd4);
        rd_chk("cnt_wr_held", 2'd1, 32'd4);
        rd_chk("cnt_wr_no_match", 2'd3, 32'd0);
        idle(1);
        rd_chk("cnt_wr_then_reload", 2'd1, 32'd0);
        wr(2'd1, 32'h0000_0100);
        rd_chk("cnt_wr_100", 2'd1, 32'h0000_0100);
        idle(1);
        rd_chk("cnt_wr_101", 2'd1, 32'h0000_0101);
        wr(2'd0, 32'd0);

        // Overflow by increment
        wr(2'd3, 32'd3);
        wr(2'd2, 32'hFFFF_0000);
        wr(2'd1, 32'hFFFF_FFFE);
        wr(2'd0, 32'h0000_0005);
        idle(1);
        rd_chk("ovf_count_ff", 2'd1, 32'hFFFF_FFFF);
        rd_chk("ovf_status_pre", 2'd3, 32'd0);
        idle(1);
        rd_chk("ovf_count_0", 2'd1, 32'd0);
        rd_chk("ovf_status", 2'd3, 32'd2);
        chk("ovf_irq", 32'(bus.irq), 32'd1);

        // Asynchronous reset mid-run, with a write pending during reset
        wr(2'd1, 32'h0000_0055);
        rd_chk("mid_count55", 2'd1, 32'h0000_0055);
        idle(2);
        rd_chk("mid_count57", 2'd1, 32'h0000_0057);
        chk("mid_irq_pre", 32'(bus.irq), 32'd1);
        bus.addr = BASE + 26'd1;
        bus.read = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", 32'(bus.oe), 32'd0);
        chk("mid_rst_irq", 32'(bus.irq), 32'd0);
        chk("mid_rst_hit", 32'(bus.hit), 32'd1);
        bus.read   = 1'b0;
        bus.write  = 1'b1;
        bus.mdrive = 1'b1;
        bus.wdata  = 32'h0000_0077;
        @(posedge clk);
        #1;
        bus.write  = 1'b0;
        bus.mdrive = 1'b0;
        rst        = 1'b0;
        #1;
        rd_chk("post_ctrl",    2'd0, 32'd0);
        rd_chk("post_count",   2'd1, 32'd0);
        rd_chk("post_compare", 2'd2, 32'd0);
        rd_chk("post_status",  2'd3, 32'd0);
        idle(2);
        rd_chk("post_idle_count", 2'd1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
